axis_pixel_transmitter: RTL



---
 rtl/axis_pixel_transmitter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/axis_pixel_transmitter.sv
// axis_pixel_transmitter
// Pipeline output stage: tags each processed pixel with start-of-frame and
// end-of-line, buffers it in a first-word-fall-through FIFO and presents it
// as an AXI4-Stream master. Upstream cannot stall, so pixels arriving while
// the FIFO is full (and not popping) are dropped and flagged.
module axis_pixel_transmitter #(
   parameter int DATA_WIDTH         = 8,
   parameter int FIFO_DEPTH         = 16,
   parameter int ALMOST_FULL_MARGIN = 4
) (
   input  logic                          i_clk,
   input  logic                          i_areset,
   input  logic [12:0]                   IMAGE_WIDTH,
   input  logic [DATA_WIDTH-1:0]         i_data,
   input  logic                          i_data_valid,
   input  logic                          i_start_of_frame,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tuser,
   output logic                          m_axis_tlast,
   output logic                          o_almost_full,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
   output logic                          o_overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = DATA_WIDTH + 2;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AF_THRESH  = CW'(FIFO_DEPTH - ALMOST_FULL_MARGIN);

   // A programmed width of zero behaves as a one-pixel line.
   function automatic logic [12:0] eff_width(input logic [12:0] w);
      return (w == 13'd0) ? 13'd1 : w;
   endfunction

   // True when the given column is the final column of a line.
   function automatic logic is_last_col(input logic [12:0] c, input logic [12:0] w);
      return (c == (eff_width(w) - 13'd1));
   endfunction

   // Control state
   logic [12:0]   col;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          af_q;
   logic          ovf_q;

   // Storage (data only, never reset)
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [EW-1:0] head;

   // Input tagging stage
   logic [12:0]   pix_col_p0;
   logic          eol_p0;
   logic [12:0]   col_next_p0;
   logic [EW-1:0] entry_p0;
   logic          full;
   logic          pop;
   logic          push_p0;
   logic          drop_p0;

   // Column of the incoming pixel, its end-of-line tag and the packed entry.
   always_comb begin
      pix_col_p0  = i_start_of_frame ? 13'd0 : col;
      eol_p0      = is_last_col(pix_col_p0, IMAGE_WIDTH);
      col_next_p0 = eol_p0 ? 13'd0 : (pix_col_p0 + 13'd1);
      entry_p0    = {i_start_of_frame, eol_p0, i_data};
   end

   // Push/pop/drop decisions; a full FIFO that is popping still accepts.
   always_comb begin
      full    = (count == FULL_COUNT);
      pop     = m_axis_tvalid && m_axis_tready;
      push_p0 = i_data_valid && (!full || pop);
      drop_p0 = i_data_valid && full && !pop;
   end

   // Next occupancy; simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_next = count;
      case ({push_p0, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // FIFO storage stage
   // Write the tagged pixel into the slot at the write pointer.
   always_ff @(posedge i_clk) begin
      if (push_p0) begin
         mem[wr_ptr] <= entry_p0;
      end
   end

   // Pointers, occupancy and the registered almost-full flag.
   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         af_q   <= 1'b0;
      end else begin
         if (push_p0) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_next;
         af_q  <= (count_next >= AF_THRESH);
      end
   end

   // Column tracking advances on every strobe, dropped or not, to keep alignment.
   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         col <= 13'd0;
      end else if (i_data_valid) begin
         col <= col_next_p0;
      end
   end

   // Sticky record that a pixel was lost.
   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         ovf_q <= 1'b0;
      end else if (drop_p0) begin
         ovf_q <= 1'b1;
      end
   end

   // Output stage
   // Head entry drives the stream; gating by tvalid forces zeros while empty or in reset.
   always_comb begin
      head          = mem[rd_ptr];
      m_axis_tvalid = (count != '0);
      m_axis_tdata  = m_axis_tvalid ? head[DATA_WIDTH-1:0] : '0;
      m_axis_tlast  = m_axis_tvalid ? head[DATA_WIDTH]     : 1'b0;
      m_axis_tuser  = m_axis_tvalid ? head[DATA_WIDTH+1]   : 1'b0;
      o_fifo_count  = count;
      o_almost_full = af_q;
      o_overflow    = ovf_q;
   end

endmodule
